// File: rtl/hazard_ctrl.sv
// Decode-side hazard controller: RAW detection against in-flight stages with
// youngest-first bypass selection, CSR interlock, redirect flush sequencing and stall statistics.
module hazard_ctrl #(
    parameter int unsigned NumStages    = 3,
    parameter int unsigned RfAddrWidth  = 5,
    parameter int unsigned CsrAddrWidth = 12,
    parameter int unsigned FwdEnable    = 1,
    parameter int unsigned FlushCycles  = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 dec_ready_i,
    input  logic [RfAddrWidth-1:0]               rs1_i,
    input  logic [RfAddrWidth-1:0]               rs2_i,
    input  logic [CsrAddrWidth-1:0]              csr_raddr_i,
    input  logic [NumStages*RfAddrWidth-1:0]     stg_rd_i,
    input  logic [NumStages-1:0]                 stg_rd_we_i,
    input  logic [NumStages-1:0]                 stg_data_ready_i,
    input  logic [NumStages-1:0]                 stg_csr_we_i,
    input  logic [NumStages*CsrAddrWidth-1:0]    stg_csr_waddr_i,
    input  logic                                 redirect_i,
    input  logic                                 mem_ready_i,
    input  logic                                 stat_clr_i,
    output logic                                 rs1_dirty_o,
    output logic                                 rs2_dirty_o,
    output logic                                 csr_dirty_o,
    output logic [$clog2(NumStages+1)-1:0]       rs1_fwd_sel_o,
    output logic [$clog2(NumStages+1)-1:0]       rs2_fwd_sel_o,
    output logic                                 softresetn_o,
    output logic                                 flush_busy_o,
    output logic [15:0]                          stall_cnt_o
);

    localparam int unsigned SelW  = $clog2(NumStages + 1);
    localparam int unsigned CntW  = 4;
    localparam int unsigned StatW = 16;

    typedef enum logic {ST_IDLE, ST_HOLD} state_e;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [RfAddrWidth-1:0]    rs1_q, rs1_d, rs2_q, rs2_d;
    logic [CsrAddrWidth-1:0]   csr_q, csr_d;
    logic [StatW-1:0]          stall_q, stall_d;

    logic                      flush_req, flush_c;
    logic                      rs1_hit, rs1_rdy, rs2_hit, rs2_rdy, csr_hit;
    logic [SelW-1:0]           rs1_sel, rs2_sel;

    // Flush sequencer: accept cycle plus FlushCycles-1 HOLD cycles
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i && mem_ready_i) begin
                    flush_req = 1'b1;
                    if (FlushCycles > 1) begin
                        state_d = ST_HOLD;
                        cnt_d   = CntW'(FlushCycles - 1);
                    end
                end
            end
            ST_HOLD: begin
                flush_req = 1'b1;
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset must release the flush immediately, even before state clears on an edge
    assign flush_c      = flush_req & ~rst_i;
    assign softresetn_o = ~flush_c;
    assign flush_busy_o = flush_c;

    // Youngest matching stage wins; x0 and CSR 0 never match
    always_comb begin
        rs1_hit = 1'b0;
        rs1_rdy = 1'b0;
        rs1_sel = '0;
        rs2_hit = 1'b0;
        rs2_rdy = 1'b0;
        rs2_sel = '0;
        csr_hit = 1'b0;
        for (int k = 0; k < NumStages; k++) begin
            if (!rs1_hit && stg_rd_we_i[k] && (rs1_q != '0) &&
                (stg_rd_i[k*RfAddrWidth +: RfAddrWidth] == rs1_q)) begin
                rs1_hit = 1'b1;
                rs1_rdy = stg_data_ready_i[k];
                rs1_sel = SelW'(k + 1);
            end
            if (!rs2_hit && stg_rd_we_i[k] && (rs2_q != '0) &&
                (stg_rd_i[k*RfAddrWidth +: RfAddrWidth] == rs2_q)) begin
                rs2_hit = 1'b1;
                rs2_rdy = stg_data_ready_i[k];
                rs2_sel = SelW'(k + 1);
            end
            if (stg_csr_we_i[k] && (csr_q != '0) &&
                (stg_csr_waddr_i[k*CsrAddrWidth +: CsrAddrWidth] == csr_q)) begin
                csr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        rs1_dirty_o   = 1'b0;
        rs2_dirty_o   = 1'b0;
        csr_dirty_o   = 1'b0;
        rs1_fwd_sel_o = '0;
        rs2_fwd_sel_o = '0;
        if (!flush_c) begin
            csr_dirty_o = csr_hit;
            if (FwdEnable != 0) begin
                rs1_dirty_o   = rs1_hit & ~rs1_rdy;
                rs2_dirty_o   = rs2_hit & ~rs2_rdy;
                rs1_fwd_sel_o = (rs1_hit && rs1_rdy) ? rs1_sel : '0;
                rs2_fwd_sel_o = (rs2_hit && rs2_rdy) ? rs2_sel : '0;
            end else begin
                rs1_dirty_o = rs1_hit;
                rs2_dirty_o = rs2_hit;
            end
        end
    end

    // Source capture; a flush squashes whatever decode holds
    always_comb begin
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        csr_d = csr_q;
        if (flush_c) begin
            rs1_d = '0;
            rs2_d = '0;
            csr_d = '0;
        end else if (dec_ready_i) begin
            rs1_d = rs1_i;
            rs2_d = rs2_i;
            csr_d = csr_raddr_i;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (stat_clr_i) begin
            stall_d = '0;
        end else if ((rs1_dirty_o || rs2_dirty_o || csr_dirty_o) && (stall_q != '1)) begin
            stall_d = stall_q + StatW'(1);
        end
    end

    assign stall_cnt_o = stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            csr_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            csr_q   <= csr_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a bypass instance (FlushCycles=3) and a stall-only instance
// (FlushCycles=1) share stimulus and are compared every cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned NS = 3;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 12;
    localparam int unsigned SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, dec_ready, redirect, mem_ready, stat_clr;
    logic [RW-1:0]    rs1, rs2;
    logic [CW-1:0]    csr;
    logic [NS*RW-1:0] stg_rd;
    logic [NS-1:0]    rd_we, data_rdy, csr_we;
    logic [NS*CW-1:0] csr_waddr;

    logic             rs1_dirty[2], rs2_dirty[2], csr_dirty[2], srn[2], busy[2];
    logic [SW-1:0]    sel1[2], sel2[2];
    logic [15:0]      stall[2];

    hazard_ctrl #(.FwdEnable(1), .FlushCycles(3)) u_fwd (
        .clk_i(clk), .rst_i(rst), .dec_ready_i(dec_ready),
        .rs1_i(rs1), .rs2_i(rs2), .csr_raddr_i(csr),
        .stg_rd_i(stg_rd), .stg_rd_we_i(rd_we), .stg_data_ready_i(data_rdy),
        .stg_csr_we_i(csr_we), .stg_csr_waddr_i(csr_waddr),
        .redirect_i(redirect), .mem_ready_i(mem_ready), .stat_clr_i(stat_clr),
        .rs1_dirty_o(rs1_dirty[0]), .rs2_dirty_o(rs2_dirty[0]), .csr_dirty_o(csr_dirty[0]),
        .rs1_fwd_sel_o(sel1[0]), .rs2_fwd_sel_o(sel2[0]),
        .softresetn_o(srn[0]), .flush_busy_o(busy[0]), .stall_cnt_o(stall[0])
    );

    hazard_ctrl #(.FwdEnable(0), .FlushCycles(1)) u_stl (
        .clk_i(clk), .rst_i(rst), .dec_ready_i(dec_ready),
        .rs1_i(rs1), .rs2_i(rs2), .csr_raddr_i(csr),
        .stg_rd_i(stg_rd), .stg_rd_we_i(rd_we), .stg_data_ready_i(data_rdy),
        .stg_csr_we_i(csr_we), .stg_csr_waddr_i(csr_waddr),
        .redirect_i(redirect), .mem_ready_i(mem_ready), .stat_clr_i(stat_clr),
        .rs1_dirty_o(rs1_dirty[1]), .rs2_dirty_o(rs2_dirty[1]), .csr_dirty_o(csr_dirty[1]),
        .rs1_fwd_sel_o(sel1[1]), .rs2_fwd_sel_o(sel2[1]),
        .softresetn_o(srn[1]), .flush_busy_o(busy[1]), .stall_cnt_o(stall[1])
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model state per instance
    int            m_fc[2]  = '{3, 1};
    int            m_fwd[2] = '{1, 0};
    logic [RW-1:0] m_rs1[2], m_rs2[2];
    logic [CW-1:0] m_csr[2];
    int            m_left[2];
    int            m_stall[2];

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    function automatic bit flushing(input int d);
        if (rst) return 1'b0;
        return (m_left[d] > 0) || (redirect && mem_ready);
    endfunction

    // {dirty, sel}
    function automatic logic [2:0] exp_gpr(input int d, input logic [RW-1:0] src);
        logic [RW-1:0] rd;
        if (flushing(d) || src == '0) return 3'b000;
        for (int k = 0; k < NS; k++) begin
            rd = stg_rd[k*RW +: RW];
            if (rd_we[k] && rd == src) begin
                if (m_fwd[d] == 0 || !data_rdy[k]) return 3'b100;
                return {1'b0, 2'(k + 1)};
            end
        end
        return 3'b000;
    endfunction

    function automatic bit exp_csr(input int d, input logic [CW-1:0] src);
        logic [CW-1:0] wa;
        if (flushing(d) || src == '0) return 1'b0;
        for (int k = 0; k < NS; k++) begin
            wa = csr_waddr[k*CW +: CW];
            if (csr_we[k] && wa == src) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rs1[d] = '0; m_rs2[d] = '0; m_csr[d] = '0;
            m_left[d] = 0; m_stall[d] = 0;
        end
    endtask

    task automatic check_all();
        logic [2:0] e1, e2;
        bit ec, fl;
        for (int d = 0; d < 2; d++) begin
            e1 = exp_gpr(d, m_rs1[d]);
            e2 = exp_gpr(d, m_rs2[d]);
            ec = exp_csr(d, m_csr[d]);
            fl = flushing(d);
            chk("rs1_dirty", d, 32'(rs1_dirty[d]), 32'(e1[2]));
            chk("rs1_sel",   d, 32'(sel1[d]),      32'(e1[1:0]));
            chk("rs2_dirty", d, 32'(rs2_dirty[d]), 32'(e2[2]));
            chk("rs2_sel",   d, 32'(sel2[d]),      32'(e2[1:0]));
            chk("csr_dirty", d, 32'(csr_dirty[d]), 32'(ec));
            chk("softresetn",d, 32'(srn[d]),       32'(!fl));
            chk("flush_busy",d, 32'(busy[d]),      32'(fl));
            chk("stall_cnt", d, 32'(stall[d]),     32'(m_stall[d]));
        end
    endtask

    task automatic model_update();
        logic [2:0] e1, e2;
        bit dirty, fl;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_rs1[d] = '0; m_rs2[d] = '0; m_csr[d] = '0;
                m_left[d] = 0; m_stall[d] = 0;
            end else begin
                e1 = exp_gpr(d, m_rs1[d]);
                e2 = exp_gpr(d, m_rs2[d]);
                dirty = e1[2] | e2[2] | exp_csr(d, m_csr[d]);
                fl = flushing(d);
                if (stat_clr) m_stall[d] = 0;
                else if (dirty && m_stall[d] < 65535) m_stall[d]++;
                if (fl) begin
                    m_rs1[d] = '0; m_rs2[d] = '0; m_csr[d] = '0;
                end else if (dec_ready) begin
                    m_rs1[d] = rs1; m_rs2[d] = rs2; m_csr[d] = csr;
                end
                if (m_left[d] > 0) m_left[d]--;
                else if (redirect && mem_ready) m_left[d] = m_fc[d] - 1;
            end
        end
    endtask

    // Check at the falling edge, advance the model at the rising edge
    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        dec_ready = 1'b1; redirect = 1'b0; mem_ready = 1'b0; stat_clr = 1'b0;
        rs1 = '0; rs2 = '0; csr = '0;
        stg_rd = '0; rd_we = '0; data_rdy = '0; csr_we = '0; csr_waddr = '0;
    endtask

    task automatic rand_inputs();
        dec_ready = ($urandom_range(0, 3) != 0);
        redirect  = ($urandom_range(0, 7) == 0);
        mem_ready = ($urandom_range(0, 3) != 0);
        stat_clr  = ($urandom_range(0, 31) == 0);
        rs1 = RW'($urandom_range(0, 7));
        rs2 = RW'($urandom_range(0, 7));
        csr = ($urandom_range(0, 3) == 0) ? 12'h000 : CW'(12'h300 + $urandom_range(0, 1));
        for (int k = 0; k < NS; k++) begin
            stg_rd[k*RW +: RW]    = RW'($urandom_range(0, 7));
            csr_waddr[k*CW +: CW] = CW'(12'h300 + $urandom_range(0, 1));
        end
        rd_we    = NS'($urandom);
        data_rdy = NS'($urandom);
        csr_we   = NS'($urandom_range(0, 7) & $urandom_range(0, 7));
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_reset();
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Bypass of a not-yet-ready then ready youngest stage
        rs1 = 5'd5;
        cyc();
        stg_rd = {5'd0, 5'd0, 5'd5}; rd_we = 3'b001; data_rdy = 3'b000;
        #1;
        chk("s36_dirty_wait", 0, 32'(rs1_dirty[0]), 32'd1);
        chk("s36_stall_mode", 1, 32'(rs1_dirty[1]), 32'd1);
        data_rdy = 3'b001;
        #1;
        chk("s36_dirty_rdy", 0, 32'(rs1_dirty[0]), 32'd0);
        chk("s36_sel_rdy",   0, 32'(sel1[0]),      32'd1);
        cyc();

        // Youngest of two matches, then x0
        rs2 = 5'd7; stg_rd = {5'd7, 5'd0, 5'd7}; rd_we = 3'b101; data_rdy = 3'b111;
        cyc();
        chk("s37_sel_young", 0, 32'(sel2[0]),      32'd1);
        chk("s37_dirty",     0, 32'(rs2_dirty[0]), 32'd0);
        rs2 = 5'd0; stg_rd = '0;
        cyc();
        chk("s37_x0_dirty",  0, 32'(rs2_dirty[0]), 32'd0);
        chk("s37_x0_sel",    0, 32'(sel2[0]),      32'd0);

        // Stall-only instance on the oldest stage
        rs1 = 5'd3; stg_rd = {5'd3, 5'd0, 5'd0}; rd_we = 3'b100;
        cyc();
        chk("s38_dirty",     1, 32'(rs1_dirty[1]), 32'd1);
        chk("s38_sel",       1, 32'(sel1[1]),      32'd0);
        chk("s38_fwd_sel",   0, 32'(sel1[0]),      32'd3);
        rd_we = 3'b000;
        #1;
        chk("s38_clear",     1, 32'(rs1_dirty[1]), 32'd0);
        cyc();

        // Flush gated by mem_ready, 3-cycle pulse, HOLD ignores redirect
        clear_inputs();
        rs1 = 5'd9;
        cyc();
        dec_ready = 1'b0; redirect = 1'b1; mem_ready = 1'b0;
        cyc();
        cyc();
        chk("s39_blocked", 0, 32'(srn[0]), 32'd1);
        mem_ready = 1'b1;
        #1;
        chk("s39_accept_srn",  0, 32'(srn[0]),  32'd0);
        chk("s39_accept_busy", 0, 32'(busy[0]), 32'd1);
        cyc();
        chk("s39_hold1", 0, 32'(srn[0]), 32'd0);
        cyc();
        chk("s39_hold2", 0, 32'(srn[0]), 32'd0);
        redirect = 1'b0;
        cyc();
        chk("s39_done", 0, 32'(srn[0]), 32'd1);
        stg_rd = {5'd0, 5'd0, 5'd9}; rd_we = 3'b001; data_rdy = 3'b000;
        #1;
        chk("s39_src_zero", 0, 32'(rs1_dirty[0]), 32'd0);
        chk("s39_src_zero", 1, 32'(rs1_dirty[1]), 32'd0);
        cyc();

        // CSR interlock and stall counter saturation
        clear_inputs();
        csr = 12'h300; csr_we = 3'b010; csr_waddr = {12'h000, 12'h300, 12'h000};
        cyc();
        chk("s40_csr_dirty", 0, 32'(csr_dirty[0]), 32'd1);
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        chk("s40_cleared", 0, 32'(stall[0]), 32'd0);
        repeat (65534) cyc();
        chk("s40_fffe", 0, 32'(stall[0]), 32'hFFFE);
        cyc();
        cyc();
        chk("s40_sat", 0, 32'(stall[0]), 32'hFFFF);
        chk("s40_sat", 1, 32'(stall[1]), 32'hFFFF);
        cyc();
        chk("s40_hold", 0, 32'(stall[0]), 32'hFFFF);
        stat_clr = 1'b1;
        cyc();
        chk("s40_clr", 0, 32'(stall[0]), 32'd0);
        clear_inputs();
        cyc();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cyc();
        end

        // Asynchronous reset in the middle of HOLD
        clear_inputs();
        redirect = 1'b1; mem_ready = 1'b1;
        cyc();
        redirect = 1'b0;
        cyc();
        #2;
        chk("s41_in_hold", 0, 32'(srn[0]), 32'd0);
        rst = 1'b1;
        #1;
        chk("s41_srn",  0, 32'(srn[0]),  32'd1);
        chk("s41_busy", 0, 32'(busy[0]), 32'd0);
        chk("s41_srn",  1, 32'(srn[1]),  32'd1);
        model_reset();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rand_inputs();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
